// File: rtl/mmio_frame_bridge_pkg.sv
// Shared constants for the MMIO frame bridge: register offsets, bit indices, key entry width.
package mmio_frame_bridge_pkg;

  localparam int unsigned KEY_W = 8;

  // Control register offsets, relative to the end of the SHADOW bank (offset NUM_CH)
  localparam int unsigned OFF_CTRL   = 0;
  localparam int unsigned OFF_STATUS = 1;
  localparam int unsigned OFF_KEYPOP = 2;
  localparam int unsigned OFF_FRAME  = 3;
  localparam int unsigned OFF_SCORE  = 4;
  localparam int unsigned REG_SPAN   = 5;

  localparam int unsigned CTRL_COMMIT_EN    = 0;
  localparam int unsigned CTRL_FORCE_COMMIT = 1;

  localparam int unsigned ST_NONEMPTY = 0;
  localparam int unsigned ST_OVERFLOW = 1;
  localparam int unsigned ST_FULL     = 2;

  // KEYPOP valid flag sits in the MSB of the bus word
  function automatic int unsigned keypop_valid_bit(input int unsigned data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/mmio_frame_bridge_key_event_fifo.sv
// Synchronous key-event FIFO with extra-MSB pointers and a sticky overflow flag.
module key_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         ovf_clr,
  output logic [W-1:0] head_c,
  output logic         empty_c,
  output logic         full_c,
  output logic         overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [W-1:0]     mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
  assign head_c  = mem[rd_ptr[PTR_W-2:0]];

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign do_pop  = pop & ~empty_c;
  assign do_push = push & (~full_c | do_pop);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !do_push) overflow <= 1'b1;
      else if (ovf_clr)     overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[PTR_W-2:0]] <= push_data;
  end

endmodule

// File: rtl/mmio_frame_bridge.sv
// Memory-mapped bridge: shadowed sprite channels committed on VS fall, key FIFO, frame counter, score.
module mmio_frame_bridge
  import mmio_frame_bridge_pkg::*;
#(
  parameter int unsigned        NUM_CH     = 8,
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        ADDR_W     = 12,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = 12'hF00,
  parameter int unsigned        KEYQ_DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [ADDR_W-1:0]        bus_addr,
  input  logic [DATA_W-1:0]        bus_wdata,
  input  logic                     bus_wren,
  input  logic                     bus_rden,
  output logic [DATA_W-1:0]        bus_rdata,
  input  logic                     vsync_n_async,
  input  logic [KEY_W-1:0]         key_data,
  input  logic                     key_pressed,
  output logic [NUM_CH*DATA_W-1:0] ch_pos,
  output logic [15:0]              frame_cnt,
  output logic [DATA_W-1:0]        score_out,
  output logic                     key_irq
);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(NUM_CH + OFF_CTRL);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(NUM_CH + OFF_STATUS);
  localparam logic [ADDR_W-1:0] A_KEYPOP = ADDR_W'(NUM_CH + OFF_KEYPOP);
  localparam logic [ADDR_W-1:0] A_FRAME  = ADDR_W'(NUM_CH + OFF_FRAME);
  localparam logic [ADDR_W-1:0] A_SCORE  = ADDR_W'(NUM_CH + OFF_SCORE);
  localparam int unsigned       VALID_B  = keypop_valid_bit(DATA_W);

  logic [DATA_W-1:0] shadow [NUM_CH];
  logic [ADDR_W-1:0] off;
  logic [DATA_W-1:0] rd_val;
  logic [2:0]        vs_s;
  logic              commit_ev;
  logic              commit_en;
  logic              force_pend;
  logic              key_prev;
  logic              wr_ctrl;
  logic [KEY_W-1:0]  fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_ovf;

  // Addresses below BASE_ADDR wrap to large offsets and decode as nothing
  assign off       = bus_addr - BASE_ADDR;
  assign wr_ctrl   = bus_wren && (off == A_CTRL);
  assign commit_ev = vs_s[2] & ~vs_s[1];
  assign key_irq   = ~fifo_empty;

  key_event_fifo #(
    .DEPTH (KEYQ_DEPTH),
    .W     (KEY_W)
  ) u_keyq (
    .clock     (clock),
    .resetn    (resetn),
    .push      (key_pressed & ~key_prev),
    .push_data (key_data),
    .pop       (bus_rden && (off == A_KEYPOP)),
    .ovf_clr   (bus_wren && (off == A_STATUS) && bus_wdata[ST_OVERFLOW]),
    .head_c    (fifo_head),
    .empty_c   (fifo_empty),
    .full_c    (fifo_full),
    .overflow  (fifo_ovf)
  );

  // Read mux; unmapped offsets fall through to zero
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (off == ADDR_W'(i)) rd_val = shadow[i];
    end
    if (off == A_CTRL) begin
      rd_val[CTRL_COMMIT_EN] = commit_en;
    end else if (off == A_STATUS) begin
      rd_val[ST_NONEMPTY] = ~fifo_empty;
      rd_val[ST_OVERFLOW] = fifo_ovf;
      rd_val[ST_FULL]     = fifo_full;
    end else if (off == A_KEYPOP) begin
      if (!fifo_empty) begin
        rd_val[VALID_B]   = 1'b1;
        rd_val[KEY_W-1:0] = fifo_head;
      end
    end else if (off == A_FRAME) begin
      rd_val = DATA_W'(frame_cnt);
    end else if (off == A_SCORE) begin
      rd_val = score_out;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vs_s       <= '0;
      key_prev   <= 1'b0;
      bus_rdata  <= '0;
      commit_en  <= 1'b1;
      force_pend <= 1'b0;
      score_out  <= '0;
      frame_cnt  <= '0;
      ch_pos     <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) shadow[i] <= '0;
    end else begin
      vs_s       <= {vs_s[1:0], vsync_n_async};
      key_prev   <= key_pressed;
      force_pend <= wr_ctrl && bus_wdata[CTRL_FORCE_COMMIT];
      if (bus_rden) bus_rdata <= rd_val;
      if (wr_ctrl) commit_en <= bus_wdata[CTRL_COMMIT_EN];
      if (bus_wren && (off == A_SCORE)) score_out <= bus_wdata;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (bus_wren && (off == ADDR_W'(i))) shadow[i] <= bus_wdata;
      end
      if (commit_ev) frame_cnt <= frame_cnt + 16'd1;
      // Copy sees pre-write shadow values, so a same-cycle write lands next frame
      if ((commit_ev && commit_en) || force_pend) begin
        for (int i = 0; i < int'(NUM_CH); i++) ch_pos[i*DATA_W +: DATA_W] <= shadow[i];
      end
    end
  end

endmodule
